// File: rtl/pipe_types_pkg.sv
// rtl/pipe_types_pkg.sv - shared pipeline types for the hazard scoreboard
// Purpose: scoreboard entry layout, drain FSM states and sizing constants.
// Ports:   none (package).
package pipe_types_pkg;

  localparam int SB_NREGS = 32;
  localparam int SB_LAT_W = 3;
  localparam int SB_NFU   = 4;
  localparam int SB_FU_W  = $clog2(SB_NFU);

  typedef enum logic [1:0] {
    HZ_RUN,
    HZ_DRAIN,
    HZ_HALTED
  } hz_state_t;

  typedef struct packed {
    logic                pend;
    logic [SB_LAT_W-1:0] cnt;
    logic [SB_FU_W-1:0]  fu;
  } sb_entry_t;

endpackage

// File: rtl/hazard_sb_entry.sv
// rtl/hazard_sb_entry.sv - one register's in-flight write tracking entry
// Purpose: holds pend/cnt/fu for a single architectural register.
// Ports:   CLK, nRST        clock, async active-low reset
//          alloc            new writer issued to this register
//          alloc_lat/fu     latency and producing unit of the new writer
//          retire           a writeback port retired this register
//          mem_stall        freezes the countdown
//          entry            current entry state
module hazard_sb_entry
  import pipe_types_pkg::*;
(
  input  logic                CLK,
  input  logic                nRST,
  input  logic                alloc,
  input  logic [SB_LAT_W-1:0] alloc_lat,
  input  logic [SB_FU_W-1:0]  alloc_fu,
  input  logic                retire,
  input  logic                mem_stall,
  output sb_entry_t           entry
);

  // Allocation outranks retire: the allocating instruction is the newer writer.
  // A fresh allocation does not count down in its own cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      entry <= '0;
    end else if (alloc) begin
      entry.pend <= 1'b1;
      entry.cnt  <= alloc_lat;
      entry.fu   <= alloc_fu;
    end else if (retire) begin
      entry <= '0;
    end else if (entry.pend && (entry.cnt != '0) && !mem_stall) begin
      entry.cnt <= entry.cnt - 1'b1;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register hazard scoreboard with drain FSM
// Purpose: tracks in-flight writes, generates issue stall and bypass selects,
//          sequences HALT through RUN -> DRAIN -> HALTED.
// Ports:   CLK, nRST                  clock, async active-low reset
//          iss_*                      issue request from decode
//          flush                      squash the presented instruction
//          mem_stall                  freeze all countdowns
//          wb_valid, wb_rd            writeback retirements, port k at [k*RW +: RW]
//          stall                      issue must hold
//          fwd_rs_*, fwd_rt_*         bypass enable and source unit per operand
//          busy                       any register pending
//          halted                     drain complete (sticky until reset)
//          perf_*                     saturating event counters (HAZARD_PERF_EN only)
// Optional feature macro: HAZARD_PERF_EN
// LAT_W and NFU size the issue ports; entries are laid out from the package
// constants, so keep both in step.
module hazard_scoreboard
  import pipe_types_pkg::*;
#(
  parameter int NREGS = SB_NREGS,
  parameter int NWB   = 2,
  parameter int LAT_W = SB_LAT_W,
  parameter int NFU   = SB_NFU,
  localparam int RW   = $clog2(NREGS),
  localparam int FW   = $clog2(NFU)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iss_valid,
  input  logic [RW-1:0]     iss_rs,
  input  logic [RW-1:0]     iss_rt,
  input  logic [RW-1:0]     iss_rd,
  input  logic              iss_regwrite,
  input  logic [LAT_W-1:0]  iss_lat,
  input  logic [FW-1:0]     iss_fu,
  input  logic              iss_halt,
  input  logic              flush,
  input  logic              mem_stall,
  input  logic [NWB-1:0]    wb_valid,
  input  logic [NWB*RW-1:0] wb_rd,
`ifdef HAZARD_PERF_EN
  output logic [31:0]       perf_raw_stalls,
  output logic [31:0]       perf_waw_stalls,
  output logic [31:0]       perf_fwd_uses,
`endif
  output logic              stall,
  output logic              fwd_rs_en,
  output logic [FW-1:0]     fwd_rs_fu,
  output logic              fwd_rt_en,
  output logic [FW-1:0]     fwd_rt_fu,
  output logic              busy,
  output logic              halted
);

  hz_state_t  state, state_nx;
  sb_entry_t  ent [NREGS];
  logic [NREGS-1:0] pend_vec;
  sb_entry_t  rs_e, rt_e;
  logic       rs_hz, rt_hz, raw_hz, waw_hz;
  logic       issue_ok, alloc, halt_go;
  logic [LAT_W-1:0] lat_eff;

  // r0 is hardwired zero and never pending.
  assign ent[0] = '0;

  genvar gi;
  for (gi = 1; gi < NREGS; gi++) begin : g_ent
    logic retire_i;
    // Several ports naming the same register collapse to one clear.
    always_comb begin
      retire_i = 1'b0;
      for (int k = 0; k < NWB; k++) begin
        if (wb_valid[k] && (wb_rd[k*RW +: RW] == RW'(gi))) retire_i = 1'b1;
      end
    end

    hazard_sb_entry u_entry (
      .CLK       (CLK),
      .nRST      (nRST),
      .alloc     (alloc && (iss_rd == RW'(gi))),
      .alloc_lat (lat_eff),
      .alloc_fu  (iss_fu),
      .retire    (retire_i),
      .mem_stall (mem_stall),
      .entry     (ent[gi])
    );
  end

  always_comb begin
    pend_vec = '0;
    for (int r = 0; r < NREGS; r++) pend_vec[r] = ent[r].pend;
  end

  assign busy = |pend_vec;

  assign rs_e   = ent[iss_rs];
  assign rt_e   = ent[iss_rt];
  assign rs_hz  = (iss_rs != '0) && rs_e.pend;
  assign rt_hz  = (iss_rt != '0) && rt_e.pend;
  assign raw_hz = (rs_hz && (rs_e.cnt != '0)) || (rt_hz && (rt_e.cnt != '0));
  assign waw_hz = iss_regwrite && (iss_rd != '0) && ent[iss_rd].pend;

  // A pending producer whose countdown has expired is on the bypass network.
  assign fwd_rs_en = rs_hz && (rs_e.cnt == '0);
  assign fwd_rt_en = rt_hz && (rt_e.cnt == '0);
  assign fwd_rs_fu = fwd_rs_en ? rs_e.fu : '0;
  assign fwd_rt_fu = fwd_rt_en ? rt_e.fu : '0;

  assign stall    = raw_hz || waw_hz || (state != HZ_RUN);
  assign issue_ok = iss_valid && !stall && !flush && (state == HZ_RUN);
  assign alloc    = issue_ok && !iss_halt && iss_regwrite && (iss_rd != '0);
  assign halt_go  = issue_ok && iss_halt;
  assign lat_eff  = (iss_lat == '0) ? LAT_W'(1) : iss_lat;
  assign halted   = (state == HZ_HALTED);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= HZ_RUN;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      HZ_RUN:    if (halt_go) state_nx = HZ_DRAIN;
      HZ_DRAIN:  if (!busy)   state_nx = HZ_HALTED;
      HZ_HALTED: state_nx = HZ_HALTED;
      default:   state_nx = HZ_RUN;
    endcase
  end

`ifdef HAZARD_PERF_EN
  // RAW and WAW are counted independently, so one cycle may bump both.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_raw_stalls <= '0;
      perf_waw_stalls <= '0;
      perf_fwd_uses   <= '0;
    end else begin
      if (iss_valid && raw_hz && (perf_raw_stalls != '1))
        perf_raw_stalls <= perf_raw_stalls + 32'd1;
      if (iss_valid && waw_hz && (perf_waw_stalls != '1))
        perf_waw_stalls <= perf_waw_stalls + 32'd1;
      if (iss_valid && !stall && (fwd_rs_en || fwd_rt_en) && (perf_fwd_uses != '1))
        perf_fwd_uses <= perf_fwd_uses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

  logic        CLK;
  logic        nRST;
  logic        iss_valid;
  logic [4:0]  iss_rs, iss_rt, iss_rd;
  logic        iss_regwrite;
  logic [2:0]  iss_lat;
  logic [1:0]  iss_fu;
  logic        iss_halt;
  logic        flush;
  logic        mem_stall;
  logic [1:0]  wb_valid;
  logic [9:0]  wb_rd;
  logic        stall, fwd_rs_en, fwd_rt_en, busy, halted;
  logic [1:0]  fwd_rs_fu, fwd_rt_fu;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_raw_stalls, perf_waw_stalls, perf_fwd_uses;
`endif

  int checks = 0;
  int errors = 0;

  hazard_scoreboard dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .iss_valid    (iss_valid),
    .iss_rs       (iss_rs),
    .iss_rt       (iss_rt),
    .iss_rd       (iss_rd),
    .iss_regwrite (iss_regwrite),
    .iss_lat      (iss_lat),
    .iss_fu       (iss_fu),
    .iss_halt     (iss_halt),
    .flush        (flush),
    .mem_stall    (mem_stall),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
`ifdef HAZARD_PERF_EN
    .perf_raw_stalls (perf_raw_stalls),
    .perf_waw_stalls (perf_waw_stalls),
    .perf_fwd_uses   (perf_fwd_uses),
`endif
    .stall        (stall),
    .fwd_rs_en    (fwd_rs_en),
    .fwd_rs_fu    (fwd_rs_fu),
    .fwd_rt_en    (fwd_rt_en),
    .fwd_rt_fu    (fwd_rt_fu),
    .busy         (busy),
    .halted       (halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    iss_valid = 0; iss_rs = 0; iss_rt = 0; iss_rd = 0; iss_regwrite = 0;
    iss_lat = 0; iss_fu = 0; iss_halt = 0; flush = 0; mem_stall = 0;
    wb_valid = 0; wb_rd = 0;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [4:0] rd, input logic [2:0] lat, input logic [1:0] fu);
    iss_valid = 1; iss_regwrite = 1; iss_rd = rd; iss_lat = lat; iss_fu = fu;
  endtask

  task automatic src(input logic [4:0] rs, input logic [4:0] rt);
    iss_valid = 1; iss_rs = rs; iss_rt = rt;
  endtask

  task automatic retire(input int port, input logic [4:0] rd);
    wb_valid[port] = 1'b1;
    wb_rd[port*5 +: 5] = rd;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle();
    nRST = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_fwd_rs_en", fwd_rs_en, 0);
    chk("rst_fwd_rt_en", fwd_rt_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    nRST = 1;
    cyc();

    // RAW countdown then bypass, cleared by retire
    wr(5, 3, 1); #2 chk("t1_issue_stall", stall, 0);
    cyc(); idle(); src(5, 0);
    #2 chk("t1_busy", busy, 1); chk("t1_stall_a", stall, 1);
    cyc(); #2 chk("t1_stall_b", stall, 1);
    cyc(); cyc();
    #2 chk("t1_stall_clear", stall, 0);
    chk("t1_fwd_en", fwd_rs_en, 1); chk("t1_fwd_fu", fwd_rs_fu, 1);
    chk("t1_rt_fwd_off", fwd_rt_en, 0);
    retire(0, 5); cyc(); idle(); src(5, 0);
    #2 chk("t1_fwd_after_wb", fwd_rs_en, 0); chk("t1_busy_after_wb", busy, 0);

    // mem_stall freezes the countdown
    idle(); wr(7, 2, 2); cyc(); idle();
    mem_stall = 1; src(0, 7);
    for (int i = 0; i < 4; i++) begin
      #2 chk("t2_frozen_stall", stall, 1);
      cyc();
    end
    mem_stall = 0;
    #2 chk("t2_cnt2_stall", stall, 1); cyc();
    #2 chk("t2_cnt1_stall", stall, 1); cyc();
    #2 chk("t2_fwd_stall", stall, 0);
    chk("t2_fwd_rt_en", fwd_rt_en, 1); chk("t2_fwd_rt_fu", fwd_rt_fu, 2);
    idle(); retire(1, 7); cyc(); idle();
    #2 chk("t2_busy_after_wb", busy, 0);

    // allocation beats same-cycle retire; double retire; r0 and lat 0
    wr(9, 1, 3); retire(0, 9); cyc(); idle();
    #2 chk("t3_alloc_wins", busy, 1);
    retire(0, 9); retire(1, 9); cyc(); idle();
    #2 chk("t3_double_retire", busy, 0);
    wr(0, 3, 0); cyc(); idle();
    #2 chk("t3_r0_no_alloc", busy, 0);
    wr(8, 0, 1); cyc(); idle(); src(8, 0);
    #2 chk("t3_lat0_stall", stall, 1); cyc();
    #2 chk("t3_lat0_fwd", fwd_rs_en, 1); chk("t3_lat0_nostall", stall, 0);
    idle(); retire(0, 8); cyc(); idle();

    // flush suppresses allocation only; WAW stall
    wr(3, 2, 0); cyc(); idle();
    wr(4, 1, 1); flush = 1; cyc(); idle(); src(4, 0);
    #2 chk("t4_flush_nostall", stall, 0); chk("t4_flush_nofwd", fwd_rs_en, 0);
    chk("t4_r3_survives", busy, 1);
    idle(); wr(3, 1, 1);
    #2 chk("t4_waw_stall", stall, 1);
    cyc(); idle(); retire(0, 3); cyc(); idle();
    #2 chk("t4_busy_clear", busy, 0);

    // halt drain
    wr(2, 1, 0); cyc(); idle(); wr(6, 1, 1); cyc(); idle();
    iss_valid = 1; iss_halt = 1;
    #2 chk("t5_halt_issue", stall, 0);
    cyc(); idle();
    #2 chk("t5_drain_stall", stall, 1); chk("t5_drain_halted", halted, 0);
    retire(0, 2); cyc(); idle();
    #2 chk("t5_one_left_halted", halted, 0); chk("t5_one_left_busy", busy, 1);
    retire(1, 6); cyc(); idle();
    #2 chk("t5_drained_busy", busy, 0); chk("t5_drained_halted", halted, 0);
    cyc();
    #2 chk("t5_halted", halted, 1); chk("t5_halted_stall", stall, 1);
    wr(11, 1, 0); cyc(); idle();
    #2 chk("t5_halted_no_alloc", busy, 0); chk("t5_sticky", halted, 1);
    nRST = 0;
    #1 chk("t5_rst_halted", halted, 0); chk("t5_rst_stall", stall, 0);
    nRST = 1; cyc();

    // reset in the middle of a drain
    wr(2, 4, 0); cyc(); idle();
    iss_valid = 1; iss_halt = 1; cyc(); idle();
    #2 chk("t6_drain_stall", stall, 1); chk("t6_drain_busy", busy, 1);
    nRST = 0;
    #1 chk("t6_rst_stall", stall, 0); chk("t6_rst_busy", busy, 0);
    chk("t6_rst_halted", halted, 0); chk("t6_rst_fwd", fwd_rs_en, 0);
    nRST = 1; cyc(); idle(); src(2, 0);
    #2 chk("t6_run_after_rst", stall, 0);
    cyc(); idle();

`ifdef HAZARD_PERF_EN
    wr(10, 3, 0); cyc(); idle(); src(10, 0);
    cyc(); cyc(); cyc(); idle();
    wr(10, 1, 0);
    #2 chk("p_waw_stall", stall, 1);
    cyc(); idle();
    #2 chk("p_raw", perf_raw_stalls, 3);
    chk("p_waw", perf_waw_stalls, 1);
    chk("p_fwd", perf_fwd_uses, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
